mux_16_bit_chip: RTL and testbench

//  - 16-bit bitwise 2:1 multiplexer with per-bit select; out[i] = s[i] ? b[i] : a[i].
//  - Result registered (one clock), so the word-level datapath stage drops into the pipelined core.
//  - Building block of the chip library; sits above the 1-bit mux cell.

---
 rtl/mux_16_bit_chip_pkg.sv | 8 +
 rtl/mux_16_bit_chip_if.sv | 23 ++
 rtl/mux_16_bit_chip_cell.sv | 11 +
 rtl/mux_16_bit_chip.sv | 60 ++++++
 tb/tb_mux_16_bit_chip.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/mux_16_bit_chip_pkg.sv
// Shared width and word type for the 16-bit bitwise mux chip.
package mux16_pkg;

    localparam int MUX16_WIDTH = 16;

    typedef logic [MUX16_WIDTH-1:0] mux16_word_t;

endpackage : mux16_pkg

// File: rtl/mux_16_bit_chip_if.sv
// Bus bundle for mux_16_bit_chip; the parity line exists only when MUX16_PARITY_EN is defined.
interface mux_16_bit_chip_if
    import mux16_pkg::*;
#(
    parameter int WIDTH = MUX16_WIDTH
) ();

    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] out;
`ifdef MUX16_PARITY_EN
    logic             parity;

    modport master (output en, output a, output b, output s, input  out, input  parity);
    modport slave  (input  en, input  a, input  b, input  s, output out, output parity);
`else
    modport master (output en, output a, output b, output s, input  out);
    modport slave  (input  en, input  a, input  b, input  s, output out);
`endif

endinterface : mux_16_bit_chip_if

// File: rtl/mux_16_bit_chip_cell.sv
// Combinational 1-bit 2:1 mux cell: out = sel ? b : a.
module mux_1bit_cell (
    output logic out,
    input  logic a,
    input  logic b,
    input  logic sel
);

    assign out = sel ? b : a;

endmodule : mux_1bit_cell

// File: rtl/mux_16_bit_chip.sv
// Registered WIDTH-bit bitwise 2:1 mux built from mux_1bit_cell instances.
// Optional even-parity output enabled by defining MUX16_PARITY_EN.
module mux_16_bit_chip
    import mux16_pkg::*;
#(
    parameter int WIDTH = MUX16_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_16_bit_chip_if.slave    bus
);

    logic [WIDTH-1:0] w_comb;
    logic [WIDTH-1:0] r_out;

    // One cell per bit; bits never interact.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        mux_1bit_cell u_cell (
            .out (w_comb[gi]),
            .a   (bus.a[gi]),
            .b   (bus.b[gi]),
            .sel (bus.s[gi])
        );
    end

    // Output register: async clear, load on en, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= {WIDTH{1'b0}};
        end else if (bus.en) begin
            r_out <= w_comb;
        end else begin
            r_out <= r_out;
        end
    end

    assign bus.out = r_out;

`ifdef MUX16_PARITY_EN
    logic r_parity;

    function automatic logic f_even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    // Parity is taken from the same word being loaded so it tracks out exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (bus.en) begin
            r_parity <= f_even_parity(w_comb);
        end else begin
            r_parity <= r_parity;
        end
    end

    assign bus.parity = r_parity;
`endif

endmodule : mux_16_bit_chip

// File: tb/tb_mux_16_bit_chip.sv
// Scoreboard bench for mux_16_bit_chip: driver pushes expected words, monitor pops and compares.
module tb_mux_16_bit_chip;
    import mux16_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mux16_word_t model_out;
    mux16_word_t exp_q[$];

    mux_16_bit_chip_if #(.WIDTH(MUX16_WIDTH)) bus ();

    mux_16_bit_chip #(.WIDTH(MUX16_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input mux16_word_t act, input mux16_word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference: each result bit comes from b where s is set, else from a.
    function automatic mux16_word_t ref_mux(input mux16_word_t a, input mux16_word_t b,
                                            input mux16_word_t s);
        return (a & ~s) | (b & s);
    endfunction

    // Apply one cycle of stimulus; after the edge, record what out must now be.
    task automatic step(input logic en, input mux16_word_t a, input mux16_word_t b,
                        input mux16_word_t s);
        bus.en = en;
        bus.a  = a;
        bus.b  = b;
        bus.s  = s;
        @(posedge clk);
        if (en) model_out = ref_mux(a, b, s);
        exp_q.push_back(model_out);
        #1;
    endtask

    // Monitor: out is valid every cycle, compared mid-cycle against the queue head.
    initial begin
        mux16_word_t exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("scoreboard_out", bus.out, exp);
`ifdef MUX16_PARITY_EN
                check_bit("scoreboard_parity", bus.parity, ^exp);
`endif
            end
        end
    end

    initial begin
        mux16_word_t ra, rb, rs;
        logic        ren;
        int          pick;
        n_checks  = 0;
        n_fail    = 0;
        model_out = 16'h0000;
        rst_n     = 1'b1;
        bus.en    = 1'b0;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.s     = 16'hFFFF;

        // Reset asserted before any clock edge must clear out on its own.
        #1 rst_n = 1'b0;
        #2;
        check("reset_out", bus.out, 16'h0000);
`ifdef MUX16_PARITY_EN
        check_bit("reset_parity", bus.parity, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 16'h0000, 16'hFFFF, 16'h0000);
        check("select_a", bus.out, 16'h0000);
        step(1'b1, 16'h0000, 16'hFFFF, 16'hFFFF);
        check("select_b", bus.out, 16'hFFFF);
`ifdef MUX16_PARITY_EN
        check_bit("select_b_parity", bus.parity, 1'b0);
`endif
        step(1'b1, 16'h1234, 16'hABCD, 16'h00FF);
        check("per_bit_select", bus.out, 16'h12CD);

        step(1'b1, 16'h0000, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 16'hFFFF, 16'h0000);
            check("hold", bus.out, 16'hFFFF);
        end

        step(1'b1, 16'h0000, 16'hABCD, 16'hFFFF);
        check("pre_reset_load", bus.out, 16'hABCD);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_mid_run", bus.out, 16'h0000);
        model_out = 16'h0000;
        rst_n = 1'b1;
        step(1'b1, 16'h0000, 16'hABCD, 16'hFFFF);
        check("reload_after_reset", bus.out, 16'hABCD);

        // Random traffic with boundary selects and equal inputs mixed in.
        for (int i = 0; i < 300; i++) begin
            ra   = mux16_word_t'($urandom);
            rb   = mux16_word_t'($urandom);
            rs   = mux16_word_t'($urandom);
            ren  = ($urandom_range(3, 0) != 0);
            pick = $urandom_range(7, 0);
            if (pick == 0) rs = 16'h0000;
            if (pick == 1) rs = 16'hFFFF;
            if (pick == 2) rb = ra;
            step(ren, ra, rb, rs);
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_16_bit_chip
